nibble_serial_addsub: RTL and testbench



---
 rtl/nibble_serial_addsub_if.sv | 26 ++
 rtl/nibble_serial_addsub.sv | 148 ++++++++++++++
 tb/tb_nibble_serial_addsub.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_addsub_if.sv
// Operand/result bundle between the ALU sequencer and its requester.
// The requester side (master) drives the operation; the sequencer side (slave) returns status and result.
interface nibble_serial_addsub_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output start, sub, a, b,
      input  ready, busy, done, sum, cout, overflow
   );

   modport slave (
      input  start, sub, a, b,
      output ready, busy, done, sum, cout, overflow
   );
endinterface

// File: rtl/nibble_serial_addsub.sv
// Nibble-serial add/subtract: walks WIDTH-bit operands through a 4-bit CLA stage,
// least-significant nibble first, carrying between nibbles in a register.

module cla4 (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       c0,
   output logic [3:0] f,
   output logic       c4
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = x & y;
   assign p = x ^ y;

   assign c[0] = c0;
   assign c[1] = g[0] | (p[0] & c0);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c0);

   assign f  = p ^ c[3:0];
   assign c4 = c[4];
endmodule

// state | meaning
// IDLE  | waiting for start; ready
// RUN   | one nibble per cycle through the CLA stage, NIB cycles
// DONE  | result valid, done pulse; a new start is accepted here too
module nibble_serial_addsub #(
   parameter int WIDTH = 16,
   parameter int NIB   = WIDTH / 4
) (
   input logic                  clk,
   input logic                  rst_n,
   nibble_serial_addsub_if.slave bus
);
   localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             last;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [CW+1:0]    base;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             overflow_q;

   logic [3:0]       f;
   logic             c4;

   assign base = {cnt, 2'b00};
   assign last = (cnt == CW'(NIB - 1));

   cla4 u_cla4 (
      .x  (op_a[base +: 4]),
      .y  (op_b[base +: 4]),
      .c0 (carry),
      .f  (f),
      .c4 (c4)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            // Back-to-back start: the old done still pulses this cycle.
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a       <= '0;
         op_b       <= '0;
         carry      <= 1'b0;
         cnt        <= '0;
         sum_q      <= '0;
         cout_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else if (accept) begin
         // Subtract as a + ~b + 1, with the +1 entering through the carry.
         op_a       <= bus.a;
         op_b       <= bus.sub ? ~bus.b : bus.b;
         carry      <= bus.sub;
         cnt        <= '0;
         sum_q      <= '0;
         cout_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else if (state == RUN) begin
         sum_q[base +: 4] <= f;
         carry            <= c4;
         cnt              <= cnt + CW'(1);
         if (last) begin
            cout_q     <= c4;
            overflow_q <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (f[3] != op_a[WIDTH-1]);
         end
      end
   end

   assign bus.ready    = (state == IDLE) || (state == DONE);
   assign bus.busy     = (state == RUN);
   assign bus.done     = (state == DONE);
   assign bus.sum      = sum_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed bench for nibble_serial_addsub at WIDTH=16.
module tb_nibble_serial_addsub;
   logic clk;
   logic rst_n;
   int   total;
   int   passed;

   nibble_serial_addsub_if #(.WIDTH(16)) bus ();

   nibble_serial_addsub #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives a request one cycle; returns just after the accepting edge.
   task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic s);
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.sub   = s;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Counts falling edges until done is seen; -1 if it never comes.
   task automatic wait_done(output int cycles);
      cycles = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            cycles = k;
            break;
         end
      end
   endtask

   task automatic test_reset;
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({bus.sum, bus.cout, bus.overflow, bus.done, bus.ready, bus.busy} !== {16'h0000, 5'b00010})
         $display("FAIL reset_state: got sum=%h cout=%b ovf=%b done=%b ready=%b busy=%b",
                  bus.sum, bus.cout, bus.overflow, bus.done, bus.ready, bus.busy);
      else passed++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_add_no_carry;
      logic [15:0] fill [3];
      int c;
      fill[0] = 16'h0005;
      fill[1] = 16'h0055;
      fill[2] = 16'h0555;
      launch(16'h1234, 16'h4321, 1'b0);
      @(negedge clk);
      total++;
      if (bus.busy !== 1'b1 || bus.ready !== 1'b0 || bus.sum !== 16'h0000)
         $display("FAIL run_first_cycle: busy=%b ready=%b sum=%h, want 1 0 0000", bus.busy, bus.ready, bus.sum);
      else passed++;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++;
         if (bus.sum !== fill[k]) $display("FAIL nibble_fill_%0d: got %h want %h", k, bus.sum, fill[k]);
         else passed++;
      end
      wait_done(c);
      total++;
      if (c !== 1) $display("FAIL add_latency: done at extra negedge %0d want 1 (5 total)", c);
      else passed++;
      total++;
      if ({bus.sum, bus.cout, bus.overflow} !== {16'h5555, 2'b00})
         $display("FAIL add_no_carry: got %h/%b/%b want 5555/0/0", bus.sum, bus.cout, bus.overflow);
      else passed++;
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.sum !== 16'h5555)
         $display("FAIL done_one_cycle: done=%b ready=%b sum=%h want 0 1 5555", bus.done, bus.ready, bus.sum);
      else passed++;
   endtask

   task automatic test_carry_ripple;
      int c;
      launch(16'hFFFF, 16'h0001, 1'b0);
      @(negedge clk);
      total++;
      if (dut.carry !== 1'b0) $display("FAIL carry_first: got %b want 0", dut.carry);
      else passed++;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++;
         if (dut.carry !== 1'b1) $display("FAIL carry_ripple_%0d: got %b want 1", k, dut.carry);
         else passed++;
      end
      wait_done(c);
      total++;
      if (c !== 1 || {bus.sum, bus.cout, bus.overflow} !== {16'h0000, 2'b10})
         $display("FAIL full_ripple: cyc=%0d got %h/%b/%b want 1 0000/1/0", c, bus.sum, bus.cout, bus.overflow);
      else passed++;
   endtask

   task automatic test_overflow;
      logic [15:0] va [3];
      logic [15:0] vb [3];
      logic        vs [3];
      logic [17:0] ve [3];
      int c;
      va[0] = 16'h7FFF; vb[0] = 16'h0001; vs[0] = 1'b0; ve[0] = {16'h8000, 2'b01};
      va[1] = 16'h8000; vb[1] = 16'h0001; vs[1] = 1'b1; ve[1] = {16'h7FFF, 2'b11};
      va[2] = 16'h0005; vb[2] = 16'h0007; vs[2] = 1'b1; ve[2] = {16'hFFFE, 2'b00};
      for (int k = 0; k < 3; k++) begin
         launch(va[k], vb[k], vs[k]);
         wait_done(c);
         total++;
         if (c !== 5 || {bus.sum, bus.cout, bus.overflow} !== ve[k])
            $display("FAIL arith_%0d: cyc=%0d got %h/%b/%b want 5 %h/%b/%b", k, c,
                     bus.sum, bus.cout, bus.overflow, ve[k][17:2], ve[k][1], ve[k][0]);
         else passed++;
      end
   endtask

   task automatic test_start_in_run;
      int c;
      launch(16'h1111, 16'h2222, 1'b0);
      @(negedge clk);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 16'hFFFF;
      bus.b     = 16'hFFFF;
      bus.sub   = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(c);
      total++;
      if (c !== 3 || {bus.sum, bus.cout, bus.overflow} !== {16'h3333, 2'b00})
         $display("FAIL start_ignored: cyc=%0d got %h/%b/%b want 3 3333/0/0", c, bus.sum, bus.cout, bus.overflow);
      else passed++;
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int c;
      launch(16'h1234, 16'h4321, 1'b0);
      wait_done(c);
      total++;
      if (c !== 5 || bus.sum !== 16'h5555)
         $display("FAIL b2b_first: cyc=%0d sum=%h want 5 5555", c, bus.sum);
      else passed++;
      bus.start = 1'b1;
      bus.a     = 16'h0001;
      bus.b     = 16'h0001;
      bus.sub   = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.sum !== 16'h0000)
         $display("FAIL b2b_accept: done=%b busy=%b sum=%h want 0 1 0000", bus.done, bus.busy, bus.sum);
      else passed++;
      wait_done(c);
      total++;
      if (c !== 4 || bus.sum !== 16'h0002 || bus.cout !== 1'b0)
         $display("FAIL b2b_second: cyc=%0d sum=%h cout=%b want 4 0002 0", c, bus.sum, bus.cout);
      else passed++;
      @(negedge clk);
   endtask

   task automatic test_async_reset;
      int c;
      int seen;
      launch(16'hFFFF, 16'hFFFF, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.sum, bus.cout, bus.overflow, bus.done, bus.ready, bus.busy} !== {16'h0000, 5'b00010})
         $display("FAIL async_reset: sum=%h cout=%b ovf=%b done=%b ready=%b busy=%b",
                  bus.sum, bus.cout, bus.overflow, bus.done, bus.ready, bus.busy);
      else passed++;
      #2;
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
      end
      total++;
      if (seen !== 0) $display("FAIL no_done_after_reset: got %0d active cycles want 0", seen);
      else passed++;
      launch(16'h00FF, 16'h0001, 1'b0);
      wait_done(c);
      total++;
      if (c !== 5 || {bus.sum, bus.cout, bus.overflow} !== {16'h0100, 2'b00})
         $display("FAIL post_reset_op: cyc=%0d got %h/%b/%b want 5 0100/0/0", c, bus.sum, bus.cout, bus.overflow);
      else passed++;
   endtask

   initial begin
      total  = 0;
      passed = 0;
      test_reset();
      test_add_no_carry();
      test_carry_ripple();
      test_overflow();
      test_start_in_run();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
